// File: rtl/jk_seq_pkg.sv
// Shared opcodes, FSM state encodings and default step-field width for the JK register sequencer.
package jk_seq_pkg;

    localparam int unsigned STEPW_DEFAULT = 8;

    typedef enum logic [2:0] {
        OpNop    = 3'b000,
        OpLoad   = 3'b001,
        OpClear  = 3'b010,
        OpSet    = 3'b011,
        OpUp     = 3'b100,
        OpDown   = 3'b101,
        OpToggle = 3'b110,
        OpRsvd   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/jk_reg_sequencer_if.sv
// Command and status bundle between a command source (master) and the sequencer (slave).
interface jk_reg_sequencer_if
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEPW = STEPW_DEFAULT
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [STEPW-1:0] cmd_steps;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps, abort,
        input  cmd_ready, q, qb, busy, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps, abort,
        output cmd_ready, q, qb, busy, done, wrap
    );
endinterface

// File: rtl/jk_bit.sv
// Single JK storage bit with synchronous active-high reset.
module jk_bit (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);
    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;
endmodule

// File: rtl/jk_reg_sequencer.sv
// Command-driven register built from JK bits; controller turns each op into per-bit J/K drives.
module jk_reg_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEPW = STEPW_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    jk_reg_sequencer_if.slave bus
);
    localparam logic [STEPW-1:0] StepOne = STEPW'(1);

    state_e           state_d, state_q;
    op_e              op_d, op_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [STEPW-1:0] rem_d, rem_q;
    logic             wrap_d, wrap_q;

    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] q_bits, qb_bits;
    logic [WIDTH-1:0] tgl_up, tgl_dn;
    logic             all_ones, all_zeros;

    // Counter toggle masks: a bit flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        logic up_c, dn_c;
        up_c   = 1'b1;
        dn_c   = 1'b1;
        tgl_up = '0;
        tgl_dn = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            tgl_up[i] = up_c;
            tgl_dn[i] = dn_c;
            up_c      = up_c & q_bits[i];
            dn_c      = dn_c & ~q_bits[i];
        end
        all_ones  = up_c;
        all_zeros = dn_c;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        wrap_d  = 1'b0;
        j       = '0;
        k       = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    op_d    = op_e'(bus.cmd_op);
                    data_d  = bus.cmd_data;
                    rem_d   = bus.cmd_steps;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StDone;
                unique case (op_q)
                    OpLoad: begin
                        j = data_q;
                        k = ~data_q;
                    end
                    OpClear:  k = '1;
                    OpSet:    j = '1;
                    OpToggle: begin
                        j = data_q;
                        k = data_q;
                    end
                    OpUp, OpDown: begin
                        // Zero remaining steps or abort both finish without touching q.
                        if (!bus.abort && rem_q != '0) begin
                            j      = (op_q == OpUp) ? tgl_up : tgl_dn;
                            k      = j;
                            wrap_d = (op_q == OpUp) ? all_ones : all_zeros;
                            rem_d  = rem_q - StepOne;
                            if (rem_q != StepOne) begin
                                state_d = StExec;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            data_q  <= '0;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        jk_bit u_bit (
            .clk   (clk),
            .reset (reset),
            .j     (j[g]),
            .k     (k[g]),
            .q     (q_bits[g]),
            .qb    (qb_bits[g])
        );
    end

    assign bus.q         = q_bits;
    assign bus.qb        = qb_bits;
    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q == StExec);
    assign bus.done      = (state_q == StDone);
    assign bus.wrap      = wrap_q;
endmodule
